// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v position counters, registered
// sync/active decode, line/frame start strobes and a raster-locked frame-buffer address.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int PIX_DIV   = 2,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CNT_W     = 10,
    parameter int ADDR_W    = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              frame_sync,
    output logic              pixel_tick,
    output logic [CNT_W-1:0]  h_count,
    output logic [CNT_W-1:0]  v_count,
    output logic              hsync,
    output logic              vsync,
    output logic              active,
    output logic              line_start,
    output logic              frame_start,
    output logic [ADDR_W-1:0] pix_addr
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (PIX_DIV < 1 || (H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)
        || (H_ACTIVE * V_ACTIVE) >= (1 << ADDR_W)) begin : g_bad_params
        $error("vga_timing_gen: raster does not fit CNT_W/ADDR_W, or PIX_DIV < 1");
    end

    function automatic logic in_range(logic [CNT_W-1:0] x, logic [CNT_W-1:0] lo,
                                      logic [CNT_W-1:0] hi);
        return (x >= lo) && (x <= hi);
    endfunction

    logic [DIV_W-1:0] div;
    logic             fs_prev;
    logic             ls_q;
    logic             fs_q;
    logic             tick;
    logic             resync;
    logic             sync_rise;
    logic             line_wrap;
    logic             frame_wrap;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;

    assign tick       = enable && (div == DIV_LAST);
    assign resync     = enable && frame_sync;
    assign sync_rise  = frame_sync && !fs_prev;
    assign line_wrap  = tick && (h_count == H_LAST);
    assign frame_wrap = line_wrap && (v_count == V_LAST);

    // Reset gating keeps the tick low during reset even when PIX_DIV=1 makes div==DIV_LAST.
    assign pixel_tick  = tick && !rst;
    assign line_start  = ls_q && enable;
    assign frame_start = fs_q && enable;

    // Next raster position; resync outranks the pixel tick.
    always_comb begin
        h_next = h_count;
        v_next = v_count;
        if (resync) begin
            h_next = '0;
            v_next = '0;
        end else if (tick) begin
            if (h_count == H_LAST) begin
                h_next = '0;
                v_next = (v_count == V_LAST) ? '0 : v_count + CNT_W'(1);
            end else begin
                h_next = h_count + CNT_W'(1);
            end
        end
    end

    // Sync/active are decoded from the next position so they line up with the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div      <= '0;
            h_count  <= '0;
            v_count  <= '0;
            pix_addr <= '0;
            hsync    <= ~HSYNC_POL;
            vsync    <= ~VSYNC_POL;
            active   <= 1'b1;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
            fs_prev  <= 1'b0;
        end else begin
            h_count <= h_next;
            v_count <= v_next;
            hsync   <= in_range(h_next, HS_START, HS_END) ? HSYNC_POL : ~HSYNC_POL;
            vsync   <= in_range(v_next, VS_START, VS_END) ? VSYNC_POL : ~VSYNC_POL;
            active  <= (h_next < H_ACT_C) && (v_next < V_ACT_C);

            if (resync) begin
                div <= '0;
            end else if (enable) begin
                div <= tick ? '0 : div + DIV_W'(1);
            end

            if (resync || frame_wrap) begin
                pix_addr <= '0;
            end else if (tick && active) begin
                pix_addr <= pix_addr + ADDR_W'(1);
            end

            ls_q <= resync ? sync_rise : line_wrap;
            fs_q <= resync ? sync_rise : frame_wrap;
            if (enable) begin
                fs_prev <= frame_sync;
            end
        end
    end

endmodule
